// File: rtl/mii_repeater_ctrl_pkg.sv
// Shared definitions for the MII repeater control slice: MII nibble width,
// repeater FSM state encodings and the jam pattern driven during collisions.
package mii_repeater_ctrl_pkg;

    localparam int MII_NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_JAM    = 2'd2,
        ST_JABBER = 2'd3
    } rep_state_t;

    localparam logic [MII_NIBBLE_W-1:0] JAM_NIBBLE = 4'h5;

endpackage

// File: rtl/mii_port_encoder.sv
// Classifies a per-port activity vector: none set, exactly one set, or several,
// plus the index of the lowest set bit (meaningful when exactly one is set).
module mii_port_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    output logic                 none,
    output logic                 one,
    output logic                 many,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // A vector with a single bit set has no bits left after clearing its lowest one.
    always_comb begin
        none = (vec == '0);
        one  = !none && ((vec & (vec - N'(1))) == '0);
        many = !none && !one;
    end

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/mii_repeater_ctrl.sv
// MII repeater core: arbitrates one receiving port and repeats its nibbles to
// all other ports, jams all ports on collision, and cuts off jabbering ports.
// All decisions are taken on ce ticks; outputs are registered and hold between ticks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no carrier; waiting for one or more rx_dv
//   ST_ACTIVE | single source src repeated to every other port
//   ST_JAM    | collision; jam pattern on all ports for at least MIN_JAM ticks
//   ST_JABBER | activity too long; all transmitters off until every rx_dv drops
module mii_repeater_ctrl
    import mii_repeater_ctrl_pkg::*;
#(
    parameter int PORTS        = 4,
    parameter int MIN_JAM      = 16,
    parameter int JABBER_LIMIT = 40000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [PORTS-1:0]     rx_dv,
    input  logic [PORTS-1:0]     rx_er,
    input  logic [4*PORTS-1:0]   rxd,
    output logic [PORTS-1:0]     tx_en,
    output logic [PORTS-1:0]     tx_er,
    output logic [4*PORTS-1:0]   txd,
    output logic                 col,
    output logic [PORTS-1:0]     jabber
);

    localparam int SRC_W = $clog2(PORTS);
    localparam int ACT_W = $clog2(JABBER_LIMIT + 1);
    localparam int JAM_W = $clog2(MIN_JAM + 1);
    localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(JABBER_LIMIT);
    localparam logic [JAM_W-1:0] JAM_MAX = JAM_W'(MIN_JAM);

    rep_state_t         state_q, state_nx;
    logic [SRC_W-1:0]   src_q, src_nx;
    logic [ACT_W-1:0]   act_q, act_nx, act_inc;
    logic [JAM_W-1:0]   jam_q, jam_nx, jam_inc;
    logic [PORTS-1:0]   jabber_nx;
    logic [PORTS-1:0]   src_mask;
    logic [PORTS-1:0]   tx_en_nx, tx_er_nx;
    logic [4*PORTS-1:0] txd_nx;
    logic               col_nx;
    logic [3:0]         src_nibble;

    logic               dv_none, dv_one, dv_many;
    logic [SRC_W-1:0]   dv_idx;

    mii_port_encoder #(.N(PORTS)) u_enc (
        .vec  (rx_dv),
        .none (dv_none),
        .one  (dv_one),
        .many (dv_many),
        .idx  (dv_idx)
    );

    // Next state, source and counters; the tick being evaluated already counts
    // towards the activity and jam lengths, so limits compare the incremented value.
    always_comb begin
        state_nx  = state_q;
        src_nx    = src_q;
        act_nx    = act_q;
        jam_nx    = jam_q;
        jabber_nx = jabber;
        src_mask  = PORTS'(1) << src_q;
        act_inc   = (act_q >= ACT_MAX) ? ACT_MAX : act_q + ACT_W'(1);
        jam_inc   = (jam_q >= JAM_MAX) ? JAM_MAX : jam_q + JAM_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                act_nx = '0;
                jam_nx = '0;
                if (dv_one) begin
                    state_nx = ST_ACTIVE;
                    src_nx   = dv_idx;
                    act_nx   = ACT_W'(1);
                end else if (dv_many) begin
                    state_nx = ST_JAM;
                    act_nx   = ACT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!rx_dv[src_q]) begin
                    state_nx = ST_IDLE;
                    act_nx   = '0;
                end else begin
                    act_nx = act_inc;
                    if (act_inc >= ACT_MAX) begin
                        state_nx  = ST_JABBER;
                        jabber_nx = jabber | src_mask;
                    end else if ((rx_dv & ~src_mask) != '0) begin
                        state_nx = ST_JAM;
                        jam_nx   = '0;
                    end
                end
            end
            ST_JAM: begin
                if (dv_none && jam_inc >= JAM_MAX) begin
                    state_nx = ST_IDLE;
                    act_nx   = '0;
                    jam_nx   = '0;
                end else begin
                    act_nx = act_inc;
                    jam_nx = jam_inc;
                    if (act_inc >= ACT_MAX) begin
                        state_nx  = ST_JABBER;
                        jabber_nx = jabber | rx_dv;
                    end
                end
            end
            ST_JABBER: begin
                if (dv_none) begin
                    state_nx  = ST_IDLE;
                    act_nx    = '0;
                    jam_nx    = '0;
                    jabber_nx = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so they appear one clk after the tick.
    always_comb begin
        tx_en_nx   = '0;
        tx_er_nx   = '0;
        txd_nx     = '0;
        col_nx     = 1'b0;
        src_nibble = rxd[{src_nx, 2'b00} +: 4];
        unique case (state_nx)
            ST_ACTIVE: begin
                for (int p = 0; p < PORTS; p++) begin
                    if (SRC_W'(p) != src_nx) begin
                        tx_en_nx[p]       = 1'b1;
                        tx_er_nx[p]       = rx_er[src_nx];
                        txd_nx[4*p +: 4]  = src_nibble;
                    end
                end
            end
            ST_JAM: begin
                tx_en_nx = '1;
                col_nx   = 1'b1;
                for (int p = 0; p < PORTS; p++) begin
                    txd_nx[4*p +: 4] = JAM_NIBBLE;
                end
            end
            default: ;
        endcase
    end

    // State, counters and outputs advance only on ce; reset wins regardless of ce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            act_q   <= '0;
            jam_q   <= '0;
            tx_en   <= '0;
            tx_er   <= '0;
            txd     <= '0;
            col     <= 1'b0;
            jabber  <= '0;
        end else if (ce) begin
            state_q <= state_nx;
            src_q   <= src_nx;
            act_q   <= act_nx;
            jam_q   <= jam_nx;
            tx_en   <= tx_en_nx;
            tx_er   <= tx_er_nx;
            txd     <= txd_nx;
            col     <= col_nx;
            jabber  <= jabber_nx;
        end
    end

endmodule
